// File: rtl/tri_iuq_cpl_arr_mp.sv
// Multi-port completion-queue array: WR_PORTS x RD_PORTS LUT-RAM banks resolved through a
// live-value table, with per-entry parity, sticky error flag and a post-reset clear sweep.
module tri_iuq_cpl_arr_mp #(
  parameter int DEPTH             = 64,
  parameter int ADDR_W            = 6,
  parameter int DATA_W            = 64,
  parameter int WR_PORTS          = 2,
  parameter int RD_PORTS          = 2,
  parameter bit LATCHED_READ      = 1'b1,
  parameter bit LATCHED_WRITE     = 1'b1,
  parameter bit LATCHED_READ_DATA = 1'b1,
  parameter bit BYPASS            = 1'b0
) (
  input  logic                         correct_clk,
  input  logic                         reset,
  input  logic [RD_PORTS-1:0]          re,
  input  logic [RD_PORTS*ADDR_W-1:0]   ra,
  // Read data; named dout because "do" is a reserved word.
  output logic [RD_PORTS*DATA_W-1:0]   dout,
  input  logic [WR_PORTS-1:0]          we,
  input  logic [WR_PORTS*ADDR_W-1:0]   wa,
  input  logic [WR_PORTS*DATA_W-1:0]   di,
  input  logic                         err_inj,
  input  logic                         perr_clr,
  output logic                         perr,
  output logic                         init_done
);

  localparam int LVT_W  = (WR_PORTS > 1) ? $clog2(WR_PORTS) : 1;
  localparam int WORD_W = DATA_W + 1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic                ready;

  logic [WR_PORTS-1:0]        wl_we;
  logic [WR_PORTS*ADDR_W-1:0] wl_wa;
  logic [WR_PORTS*DATA_W-1:0] wl_di;
  logic                       wl_inj;
  logic [WR_PORTS-1:0]        wr_en;

  logic [RD_PORTS-1:0]        rl_re;
  logic [RD_PORTS*ADDR_W-1:0] rl_ra;
  logic [RD_PORTS-1:0]        rd_vld;

  logic [LVT_W-1:0]                         lvt [DEPTH];
  logic [WR_PORTS-1:0][RD_PORTS-1:0][WORD_W-1:0] bank_rd;
  logic [RD_PORTS-1:0][WORD_W-1:0]          rd_sel;

  logic [RD_PORTS-1:0] chk_vld;
  logic [RD_PORTS-1:0] chk_par;
  logic                perr_hit;

  assign ready = (state == ST_READY);

  // Clear sweep: one address per cycle, DEPTH cycles, then READY until reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge correct_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == ADDR_W'(DEPTH - 1)) begin
        state     <= ST_READY;
        init_done <= 1'b1;
      end
    end
  end

  generate
    if (LATCHED_WRITE) begin : g_wlat
      always_ff @(posedge correct_clk or posedge reset) begin
        if (reset) begin
          wl_we  <= '0;
          wl_wa  <= '0;
          wl_di  <= '0;
          wl_inj <= 1'b0;
        end else begin
          wl_we  <= we & {WR_PORTS{ready}};
          wl_wa  <= wa;
          wl_di  <= di;
          wl_inj <= err_inj;
        end
      end
    end else begin : g_wdir
      assign wl_we  = we;
      assign wl_wa  = wa;
      assign wl_di  = di;
      assign wl_inj = err_inj;
    end

    if (LATCHED_READ) begin : g_rlat
      always_ff @(posedge correct_clk or posedge reset) begin
        if (reset) begin
          rl_re <= '0;
          rl_ra <= '0;
        end else begin
          rl_re <= re;
          rl_ra <= ra;
        end
      end
    end else begin : g_rdir
      assign rl_re = re;
      assign rl_ra = ra;
    end
  endgenerate

  // External writes are ignored until the sweep has finished.
  assign wr_en  = wl_we & {WR_PORTS{ready}};
  assign rd_vld = rl_re & {RD_PORTS{ready}};

  // One single-write/single-read bank per (write port, read port) pair.
  generate
    for (genvar w = 0; w < WR_PORTS; w++) begin : g_wr
      for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
        logic [WORD_W-1:0] mem [DEPTH];

        // NOTE: the storage array has no reset; the post-reset sweep clears it instead.
        always_ff @(posedge correct_clk) begin
          if (!ready)
            mem[init_cnt] <= '0;
          else if (wr_en[w])
            mem[wl_wa[w*ADDR_W +: ADDR_W]] <=
              {wl_inj ^ (^wl_di[w*DATA_W +: DATA_W]), wl_di[w*DATA_W +: DATA_W]};
        end

        assign bank_rd[w][r] = mem[rl_ra[r*ADDR_W +: ADDR_W]];
      end
    end
  endgenerate

  // Live-value table: ascending port loop makes the highest-numbered writer win a collision.
  always_ff @(posedge correct_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) lvt[i] <= '0;
    end else if (!ready) begin
      lvt[init_cnt] <= '0;
    end else begin
      for (int w = 0; w < WR_PORTS; w++)
        if (wr_en[w]) lvt[wl_wa[w*ADDR_W +: ADDR_W]] <= LVT_W'(w);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_sel = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_sel[r] = bank_rd[lvt[rl_ra[r*ADDR_W +: ADDR_W]]][r];
      if (BYPASS) begin
        for (int w = 0; w < WR_PORTS; w++)
          if (wr_en[w] && (wl_wa[w*ADDR_W +: ADDR_W] == rl_ra[r*ADDR_W +: ADDR_W]))
            rd_sel[r] = {^wl_di[w*DATA_W +: DATA_W], wl_di[w*DATA_W +: DATA_W]};
      end
    end
  end

  // Parity is checked on the word as it leaves the output stage, so perr trails dout by one edge.
  generate
    if (LATCHED_READ_DATA) begin : g_dlat
      always_ff @(posedge correct_clk or posedge reset) begin
        if (reset) begin
          dout    <= '0;
          chk_par <= '0;
          chk_vld <= '0;
        end else begin
          chk_vld <= rd_vld;
          for (int r = 0; r < RD_PORTS; r++) begin
            if (rl_re[r]) begin
              dout[r*DATA_W +: DATA_W] <= rd_sel[r][DATA_W-1:0];
              chk_par[r]               <= rd_sel[r][DATA_W];
            end
          end
        end
      end
    end else begin : g_ddir
      always_comb begin
        dout    = '0;
        chk_par = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
          dout[r*DATA_W +: DATA_W] = rd_sel[r][DATA_W-1:0];
          chk_par[r]               = rd_sel[r][DATA_W];
        end
      end
      assign chk_vld = rd_vld;
    end
  endgenerate

  always_comb begin
    perr_hit = 1'b0;
    for (int r = 0; r < RD_PORTS; r++)
      if (chk_vld[r] && ((^dout[r*DATA_W +: DATA_W]) != chk_par[r]))
        perr_hit = 1'b1;
  end

  // Sticky error: a new error dominates a simultaneous clear.
  always_ff @(posedge correct_clk or posedge reset) begin
    if (reset)
      perr <= 1'b0;
    else if (perr_hit)
      perr <= 1'b1;
    else if (perr_clr)
      perr <= 1'b0;
  end

endmodule
